// File: rtl/rob_pkg.sv
// Shared defaults, FSM encoding and request-count helper for the ROB allocator.
package rob_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_IDX_W = $clog2(ROB_DEPTH);

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } rob_state_e;

  // Number of valid slots in a 2-wide request; slot 2 without slot 1 counts as nothing.
  function automatic logic [1:0] req_count(input logic [1:0] req);
    logic [1:0] n;
    case (req)
      2'b01:   n = 2'd1;
      2'b11:   n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit circular pointer advancing by 0, 1 or 2 with synchronous clear.
module rob_ptr #(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [1:0]       adv_i,
  output logic [IDX_W:0]   ptr_o
);

  logic [IDX_W:0] ptr_q;
  logic [IDX_W:0] ptr_d;

  // Next pointer: clear wins, otherwise advance; the MSB toggles on wrap.
  always_comb begin
    ptr_d = ptr_q + (IDX_W+1)'(adv_i);
    if (clr_i) ptr_d = '0;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation/commit scheduler: 2-wide enqueue, 2-wide in-order commit, flush recovery.
module rob_alloc_ctrl
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       enq_req_i,
  output logic             enq_gnt_o,
  output logic [IDX_W-1:0] enq_idx1_o,
  output logic [IDX_W-1:0] enq_idx2_o,
  input  logic [1:0]       com_req_i,
  input  logic             flush_i,
  output logic [IDX_W-1:0] head_idx_o,
  output logic [IDX_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [DEPTH-1:0] free_vec_o
);

  rob_state_e state_q, state_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [DEPTH-1:0] free_q, free_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  logic [IDX_W:0]   head_ptr, tail_ptr;
  logic [IDX_W-1:0] head_idx, head_idx_p1, tail_idx, tail_idx_p1;
  logic [IDX_W:0]   free_slots;
  logic [1:0]       n_enq_req, n_com_req, n_enq, n_com;
  logic             gnt;
  logic             unused_wrap;

  assign head_idx    = head_ptr[IDX_W-1:0];
  assign tail_idx    = tail_ptr[IDX_W-1:0];
  assign head_idx_p1 = head_idx + IDX_W'(1);
  assign tail_idx_p1 = tail_idx + IDX_W'(1);
  assign unused_wrap = ^{head_ptr[IDX_W], tail_ptr[IDX_W]};

  // Head pointer: advances by the number of committed entries.
  rob_ptr #(.IDX_W(IDX_W)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush_i),
    .adv_i (n_com),
    .ptr_o (head_ptr)
  );

  // Tail pointer: advances by the number of granted enqueues.
  rob_ptr #(.IDX_W(IDX_W)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush_i),
    .adv_i (n_enq),
    .ptr_o (tail_ptr)
  );

  // Next-state: FSM, grant, commit count, occupancy and flag vector updates.
  always_comb begin
    state_d    = state_q;
    n_enq      = 2'd0;
    n_com      = 2'd0;
    count_d    = count_q;
    free_d     = free_q;
    n_enq_req  = req_count(enq_req_i);
    n_com_req  = req_count(com_req_i);
    free_slots = (IDX_W+1)'(DEPTH) - count_q;
    gnt        = (state_q == RUN) && (n_enq_req != 2'd0) &&
                 (free_slots >= (IDX_W+1)'(n_enq_req));

    case (state_q)
      RUN:     state_d = RUN;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase

    if (flush_i) begin
      state_d = RECOVER;
      count_d = '0;
      free_d  = '1;
    end else begin
      if (gnt) n_enq = n_enq_req;
      if (state_q == RUN) begin
        if ((IDX_W+1)'(n_com_req) > count_q) n_com = count_q[1:0];
        else                                 n_com = n_com_req;
      end
      count_d = count_q + (IDX_W+1)'(n_enq) - (IDX_W+1)'(n_com);
      // Commit sets flags first so an enqueue write would dominate on overlap.
      if (n_com != 2'd0) free_d[head_idx]    = 1'b1;
      if (n_com == 2'd2) free_d[head_idx_p1] = 1'b1;
      if (n_enq != 2'd0) free_d[tail_idx]    = 1'b0;
      if (n_enq == 2'd2) free_d[tail_idx_p1] = 1'b0;
    end

    full_d  = (count_d == (IDX_W+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Occupancy, status flags and free/valid flag vector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      free_q  <= '1;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      free_q  <= free_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign enq_gnt_o  = gnt;
  assign enq_idx1_o = tail_idx;
  assign enq_idx2_o = tail_idx_p1;
  assign head_idx_o = head_idx;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign free_vec_o = free_q;

endmodule
